piso_tx_ctrl: RTL

//  Sequencer for the parallel-in/serial-out shift register. Accepts a WIDTH-bit

---
 rtl/piso_tx_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: valid/ready sequencer driving PISO load/shift strobes and framing start/data/[parity]/stop on tx.
// Define PISO_PARITY_EN to insert an even-parity bit period between DATA and STOP.
module piso_tx_ctrl #(
    parameter int WIDTH        = 3,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] piso_par,
    output logic             piso_load,
    output logic             piso_shift,
    input  logic             piso_o,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WIDTH);
    localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TPRE  = TW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PISO_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [BW-1:0] bit_cnt;

    assign in_ready = state == IDLE;

    always_comb begin
`ifdef PISO_PARITY_EN
        tx = (state == START) ? 1'b0 : (state == DATA) ? piso_o : (state == PARITY) ? ^piso_par : 1'b1;
`else
        tx = (state == START) ? 1'b0 : (state == DATA) ? piso_o : 1'b1;
`endif
    end

    // strobes are registered one cycle early so they land on the last cycle of a bit period
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tick       <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            piso_load  <= 1'b0;
            piso_shift <= 1'b0;
            piso_par   <= '0;
        end else begin
            piso_load  <= in_valid && in_ready;
            piso_shift <= state == DATA && tick == TPRE && bit_cnt != BLAST;
            done       <= state == STOP && tick == TPRE;
            if (state == IDLE) begin
                tick <= '0;
                if (in_valid) begin
                    piso_par <= in_data;
                    state    <= START;
                    busy     <= 1'b1;
                end
            end else if (tick != TLAST) begin
                tick <= tick + 1'b1;
            end else begin
                tick <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt != BLAST) bit_cnt <= bit_cnt + 1'b1;
`ifdef PISO_PARITY_EN
                        else state <= PARITY;
                    end
                    PARITY: state <= STOP;
`else
                        else state <= STOP;
                    end
`endif
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
